// File: rtl/cache_nway_p.sv
// cache_nway_p: N-way two-stage pipelined write-back cache with tree PLRU; CPU line port (mem_*) in, memory line port (pmem_*) out
module cache_nway_p #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
  parameter int S_MASK   = 2**S_OFFSET,
  parameter int S_LINE   = 8*S_MASK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [S_LINE-1:0] mem_wdata256,
  input  logic [S_MASK-1:0] mem_byte_enable256,
  output logic              mem_ready,
  output logic              mem_resp,
  output logic [S_LINE-1:0] mem_rdata256,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int LW = $clog2(NUM_WAYS);
  localparam int NS = 2**S_INDEX;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t state_q, state_d;
  logic s2_valid_q, s2_valid_d, s2_write_q;
  logic [31-S_OFFSET:0] s2_line_q;
  logic [S_LINE-1:0] s2_wdata_q, be_mask, merged;
  logic [S_MASK-1:0] s2_be_q;
  logic [NUM_WAYS-1:0] valid_q [NS];
  logic [NUM_WAYS-1:0] dirty_q [NS];
  logic [NUM_WAYS-1:1] plru_q [NS];
  logic [NUM_WAYS-1:1] plru_upd;
  logic [S_TAG-1:0] tag_q [NUM_WAYS][NS];
  logic [S_LINE-1:0] data_q [NUM_WAYS][NS];
  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0] rtag;
  logic hit, miss, accept, fill_done, unused;
  logic [LW-1:0] hit_way, victim, way_sh;
  logic [LW:0] vnode, unode;
  assign unused = ^mem_address[S_OFFSET-1:0];
  assign idx = s2_line_q[S_INDEX-1:0];
  assign rtag = s2_line_q[S_INDEX +: S_TAG];
  assign miss = s2_valid_q && !hit;
  assign accept = (mem_read || mem_write) && mem_ready;
  assign fill_done = state_q == FILL && pmem_resp;
  assign s2_valid_d = accept || miss;
  assign mem_ready = state_q == IDLE && !miss;
  assign mem_resp = s2_valid_q && hit;
  assign mem_rdata256 = data_q[hit_way][idx];
  assign pmem_read = state_q == FILL;
  assign pmem_write = state_q == WB;
  assign pmem_address = {pmem_write ? tag_q[victim][idx] : rtag, idx, {S_OFFSET{1'b0}}};
  assign pmem_wdata = data_q[victim][idx];
  assign merged = (s2_wdata_q & be_mask) | (mem_rdata256 & ~be_mask);
  for (genvar b = 0; b < S_MASK; b++) begin : g_be
    assign be_mask[8*b +: 8] = {8{s2_be_q[b]}};
  end
  // PLRU nodes are heap-numbered from 1; a path walk shifts one way-index bit per level.
  // The arrays for the held set stay frozen during WB/FILL, so the victim need not be latched.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vnode = (LW+1)'(1);
    unode = (LW+1)'(1);
    plru_upd = plru_q[idx];
    for (int i = 0; i < LW; i++) vnode = {vnode[LW-1:0], plru_q[idx][vnode[LW-1:0]]};
    victim = vnode[LW-1:0];
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][LW'(w)] && tag_q[LW'(w)][idx] == rtag) begin
        hit = 1'b1;
        hit_way = LW'(w);
      end
      if (!valid_q[idx][LW'(w)]) victim = LW'(w);
    end
    way_sh = hit_way;
    for (int i = 0; i < LW; i++) begin
      plru_upd[unode[LW-1:0]] = ~way_sh[LW-1];
      unode = {unode[LW-1:0], way_sh[LW-1]};
      way_sh = way_sh << 1;
    end
    state_d = state_q == IDLE && miss ? (valid_q[idx][victim] && dirty_q[idx][victim] ? WB : FILL) :
              state_q == WB && pmem_resp ? FILL : fill_done ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s2_valid_q <= 1'b0;
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
      plru_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      s2_valid_q <= s2_valid_d;
      if (mem_resp) plru_q[idx] <= plru_upd;
      if (mem_resp && s2_write_q) dirty_q[idx][hit_way] <= 1'b1;
      if (fill_done) begin
        valid_q[idx][victim] <= 1'b1;
        dirty_q[idx][victim] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s2_line_q <= mem_address[31:S_OFFSET];
      s2_write_q <= mem_write;
      s2_wdata_q <= mem_wdata256;
      s2_be_q <= mem_byte_enable256;
    end
    if (!rst && mem_resp && s2_write_q) data_q[hit_way][idx] <= merged;
    if (!rst && fill_done) begin
      data_q[victim][idx] <= pmem_rdata;
      tag_q[victim][idx] <= rtag;
    end
  end
endmodule

// File: tb/tb_cache_nway_p.sv
// tb_cache_nway_p: table-driven, directed and random checks of cache_nway_p against a flat-memory model
module tb_cache_nway_p;
  typedef logic [255:0] line_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] be; logic [7:0] wb; int lat; } vec_t;
  typedef struct { bit wr; logic [31:0] a; line_t d; } tx_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  line_t mem_wdata256 = '0;
  logic [31:0] mem_byte_enable256 = '0;
  logic mem_ready, mem_resp, pmem_read, pmem_write;
  line_t mem_rdata256, pmem_wdata;
  line_t pmem_rdata = '0;
  logic pmem_resp = 1'b0;
  logic [31:0] pmem_address;
  int checks = 0, passes = 0, delay = 0, wait_cnt = 0;
  bit hold_resp = 1'b0;
  line_t phys [logic [31:0]];
  line_t gold [logic [31:0]];
  tx_t log_q [$];
  vec_t vecs [21];

  cache_nway_p dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256), .mem_ready(mem_ready),
    .mem_resp(mem_resp), .mem_rdata256(mem_rdata256), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic line_t dflt(logic [31:0] a);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ (32'h1357_9BDF * 32'(i + 1));
    return l;
  endfunction
  function automatic line_t phys_get(logic [31:0] a);
    return phys.exists(a) ? phys[a] : dflt(a);
  endfunction
  function automatic line_t gold_get(logic [31:0] a);
    return gold.exists(a) ? gold[a] : dflt(a);
  endfunction
  function automatic line_t merge(line_t old, line_t wd, logic [31:0] be);
    line_t l = old;
    for (int b = 0; b < 32; b++) if (be[b]) l[8*b +: 8] = wd[8*b +: 8];
    return l;
  endfunction

  task automatic chk(string nm, line_t act, line_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory responder: answers after `delay` waiting cycles, logs each transaction in order.
  initial forever begin
    @(negedge clk);
    pmem_resp = 1'b0;
    if (!rst && !hold_resp && (pmem_read || pmem_write)) begin
      if (wait_cnt < delay) wait_cnt++;
      else begin
        wait_cnt = 0;
        chk("pmem_req_shape", line_t'({pmem_read && pmem_write, pmem_address[4:0]}), '0);
        pmem_resp = 1'b1;
        if (pmem_write) begin
          phys[pmem_address] = pmem_wdata;
          log_q.push_back('{1'b1, pmem_address, pmem_wdata});
        end else begin
          pmem_rdata = phys_get(pmem_address);
          log_q.push_back('{1'b0, pmem_address, pmem_rdata});
        end
      end
    end
  end

  task automatic req(input bit wr, input bit rd_too, input logic [31:0] a, input line_t wd,
                     input logic [31:0] be, output line_t rd, output int lat);
    int n = 0;
    @(negedge clk);
    mem_read = !wr || rd_too;
    mem_write = wr;
    mem_address = a;
    mem_wdata256 = wd;
    mem_byte_enable256 = be;
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", line_t'(mem_ready), 1);
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    lat = 0;
    while (!mem_resp && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("req_resp", line_t'(mem_resp), 1);
    rd = mem_rdata256;
  endtask

  task automatic run_vec(int lo, int hi);
    line_t rd, wd;
    int lat;
    for (int i = lo; i <= hi; i++) begin
      wd = {32{vecs[i].wb}};
      req(vecs[i].wr, 1'b0, vecs[i].addr, wd, vecs[i].be, rd, lat);
      chk($sformatf("vec%0d_lat", i), line_t'(lat), line_t'(vecs[i].lat));
      if (vecs[i].wr) gold[vecs[i].addr] = merge(gold_get(vecs[i].addr), wd, vecs[i].be);
      else chk($sformatf("vec%0d_rdata", i), rd, gold_get(vecs[i].addr));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b2b [4];
    logic [31:0] a, la, be;
    line_t rd, wd;
    int lat, n0, bad;
    bit wr;
    vecs = '{
      '{1'b0, 32'h040, 32'h0, 8'h00, 2}, '{1'b0, 32'h040, 32'h0, 8'h00, 0},
      '{1'b0, 32'h000, 32'h0, 8'h00, 2}, '{1'b0, 32'h020, 32'h0, 8'h00, 2},
      '{1'b0, 32'h060, 32'h0, 8'h00, 2}, '{1'b1, 32'h040, 32'h0000_000F, 8'hAA, 0},
      '{1'b0, 32'h040, 32'h0, 8'h00, 0}, '{1'b0, 32'h100, 32'h0, 8'h00, 2},
      '{1'b0, 32'h200, 32'h0, 8'h00, 2}, '{1'b0, 32'h300, 32'h0, 8'h00, 2},
      '{1'b0, 32'h000, 32'h0, 8'h00, 0}, '{1'b0, 32'h400, 32'h0, 8'h00, 2},
      '{1'b0, 32'h000, 32'h0, 8'h00, 0}, '{1'b0, 32'h300, 32'h0, 8'h00, 0},
      '{1'b0, 32'h200, 32'h0, 8'h00, 2}, '{1'b1, 32'h200, 32'hFF00_0000, 8'h3C, 0},
      '{1'b0, 32'h500, 32'h0, 8'h00, 2}, '{1'b0, 32'h600, 32'h0, 8'h00, 2},
      '{1'b0, 32'h700, 32'h0, 8'h00, 2}, '{1'b0, 32'h800, 32'h0, 8'h00, 3},
      '{1'b0, 32'h200, 32'h0, 8'h00, 2}
    };
    b2b = '{32'h000, 32'h020, 32'h040, 32'h060};
    repeat (3) @(negedge clk);
    chk("rst_mem_resp", line_t'(mem_resp), 0);
    chk("rst_pmem_read", line_t'(pmem_read), 0);
    chk("rst_pmem_write", line_t'(pmem_write), 0);
    chk("rst_mem_ready", line_t'(mem_ready), 1);
    rst = 1'b0;
    n0 = log_q.size();
    run_vec(0, 0);
    chk("cold_fill_count", line_t'(log_q.size() - n0), 1);
    if (log_q.size() > n0) chk("cold_fill_addr", line_t'({log_q[n0].wr, log_q[n0].a}), line_t'(32'h40));
    run_vec(1, 4);
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = b2b[0];
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b%0d_ready", i), line_t'(mem_ready), 1);
      @(negedge clk);
      chk($sformatf("b2b%0d_resp", i), line_t'(mem_resp), 1);
      chk($sformatf("b2b%0d_rdata", i), mem_rdata256, gold_get(b2b[i]));
      if (i < 3) mem_address = b2b[i + 1];
      else mem_read = 1'b0;
    end
    run_vec(5, 18);
    n0 = log_q.size();
    run_vec(19, 19);
    chk("evict_tx_count", line_t'(log_q.size() - n0), 2);
    if (log_q.size() >= n0 + 2) begin
      chk("evict_wb_addr", line_t'({log_q[n0].wr, log_q[n0].a}), line_t'({1'b1, 32'h200}));
      chk("evict_wb_data", log_q[n0].d, gold_get(32'h200));
      chk("evict_fill_addr", line_t'({log_q[n0 + 1].wr, log_q[n0 + 1].a}), line_t'({1'b0, 32'h800}));
    end
    run_vec(20, 20);
    hold_resp = 1'b1;
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h900;
    @(negedge clk);
    mem_read = 1'b0;
    bad = 0;
    while (!pmem_read && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("rstfill_pmem_read", line_t'(pmem_read), 1);
    chk("rstfill_addr", line_t'(pmem_address), line_t'(32'h900));
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_read_low", line_t'(pmem_read), 0);
    chk("rstfill_ready", line_t'(mem_ready), 1);
    chk("rstfill_resp", line_t'(mem_resp), 0);
    chk("rstfill_write_low", line_t'(pmem_write), 0);
    rst = 1'b0;
    hold_resp = 1'b0;
    gold = phys;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_resp) bad++;
    end
    chk("rstfill_no_resp", line_t'(bad), 0);
    req(1'b0, 1'b0, 32'h900, '0, '0, rd, lat);
    chk("rstfill_remiss_lat", line_t'(lat), 2);
    chk("rstfill_remiss_rdata", rd, gold_get(32'h900));
    for (int k = 0; k < 400; k++) begin
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      la = a & ~32'h1F;
      wr = $urandom_range(0, 9) < 4;
      for (int j = 0; j < 8; j++) wd[32*j +: 32] = $urandom();
      be = $urandom();
      delay = $urandom_range(0, 2);
      req(wr, wr && $urandom_range(0, 1) == 1, a, wd, be, rd, lat);
      if (wr) gold[la] = merge(gold_get(la), wd, be);
      else chk($sformatf("rand%0d_rdata", k), rd, gold_get(la));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
